// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults and types for the UART receive buffer.
package uart_rx_fifo_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 16;
    localparam int TO_TICKS_DEF = 64;

    // Character-timeout tracker: IDLE while empty, COUNT while waiting for
    // activity, EXPIRED once the inactivity window has elapsed.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } uart_rxfifo_state_e;

endpackage

// File: rtl/uart_rx_fifo_core.sv
// Generic first-word-fall-through FIFO: storage, wrapping pointers, explicit level.
// The caller qualifies push/pop; this block trusts them and never checks full/empty.
module uart_fifo_core #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and level bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures bytes from uart_rx, flags overrun, level
// threshold and character timeout, and offers an FWFT read port.
// Interface semantics: valid_rx is a single-cycle strobe with no back-pressure;
// a byte offered while full (and not popped that cycle) is dropped and flagged.
// rd_en pops the head at the clock edge when non-empty and is ignored when empty.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TO_TICKS = TO_TICKS_DEF,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_rx,
    input  logic [DATA_W-1:0]  rsr,
    input  logic               pls_rx,
    input  logic               rd_en,
    output logic [DATA_W-1:0]  rd_data,
    output logic               empty,
    output logic               full,
    output logic [LVL_W-1:0]   level,
    input  logic [LVL_W-1:0]   thresh,
    output logic               irq_thresh,
    output logic               overrun,
    input  logic               clr_overrun,
    output logic               timeout,
    output uart_rxfifo_state_e dbg_to_state
);

    localparam int TO_W = $clog2(TO_TICKS + 1);

    logic               push;
    logic               pop;
    logic               drop;
    logic               last_out;
    uart_rxfifo_state_e state, state_n;
    logic [TO_W-1:0]    to_cnt, to_cnt_n;

    // A pop frees a slot, so a full FIFO still accepts a byte in the same cycle.
    assign pop      = rd_en && !empty;
    assign push     = valid_rx && (!full || pop);
    assign drop     = valid_rx && full && !pop;
    assign last_out = pop && !push && (level == LVL_W'(1));

    uart_fifo_core #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (rsr),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

    // Sticky overrun; a fresh drop outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    // Threshold 0 disables the interrupt; values above DEPTH can never be met.
    assign irq_thresh = (thresh != '0) && (level >= thresh);

    // Timeout state and tick counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_n;
            to_cnt <= to_cnt_n;
        end
    end

    // Timeout next-state: any push/pop restarts the window; ticks only count in COUNT.
    always_comb begin
        state_n  = state;
        to_cnt_n = to_cnt;
        case (state)
            IDLE: begin
                to_cnt_n = '0;
                if (push) state_n = COUNT;
            end
            COUNT: begin
                if (push || pop) begin
                    to_cnt_n = '0;
                    if (last_out) state_n = IDLE;
                end else if (pls_rx) begin
                    to_cnt_n = to_cnt + TO_W'(1);
                    if (to_cnt_n == TO_W'(TO_TICKS)) state_n = EXPIRED;
                end
            end
            EXPIRED: begin
                if (push || pop) begin
                    to_cnt_n = '0;
                    state_n  = last_out ? IDLE : COUNT;
                end
            end
            default: begin
                state_n  = IDLE;
                to_cnt_n = '0;
            end
        endcase
    end

    assign timeout      = (state == EXPIRED);
    assign dbg_to_state = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, plus hand-computed literal expectations for the directed tests.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH    = 16;
    localparam int DATA_W   = 8;
    localparam int TO_TICKS = 64;
    localparam int LVL_W    = 5;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               rst;
    logic               valid_rx;
    logic [DATA_W-1:0]  rsr;
    logic               pls_rx;
    logic               rd_en;
    logic [DATA_W-1:0]  rd_data;
    logic               empty;
    logic               full;
    logic [LVL_W-1:0]   level;
    logic [LVL_W-1:0]   thresh;
    logic               irq_thresh;
    logic               overrun;
    logic               clr_overrun;
    logic               timeout;
    uart_rxfifo_state_e dbg_state;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .TO_TICKS (TO_TICKS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_rx     (valid_rx),
        .rsr          (rsr),
        .pls_rx       (pls_rx),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .thresh       (thresh),
        .irq_thresh   (irq_thresh),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .timeout      (timeout),
        .dbg_to_state (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    logic [DATA_W-1:0] exp_q[$];
    bit                m_ovr;
    int                m_ticks;
    int                checks = 0;
    int                errors = 0;
    bit                run    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (run) begin
            int n;
            int exp_rd;
            n      = exp_q.size();
            exp_rd = (n > 0) ? int'(exp_q[0]) : 0;
            chk("rd_data", 32'(rd_data), 32'(exp_rd));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("full", 32'(full), 32'(n == DEPTH));
            chk("level", 32'(level), 32'(n));
            chk("irq_thresh", 32'(irq_thresh), 32'((thresh != 0) && (n >= int'(thresh))));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("timeout", 32'(timeout), 32'((n > 0) && (m_ticks >= TO_TICKS)));
        end
    end

    // ---------------- driver tasks ----------------
    // One clock cycle of stimulus; the model advances with the same inputs.
    task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic r,
                        input logic p, input logic c);
        int n;
        bit do_pop;
        bit do_push;
        bit do_drop;
        @(negedge clk);
        #1;
        valid_rx    = v;
        rsr         = d;
        rd_en       = r;
        pls_rx      = p;
        clr_overrun = c;
        n       = exp_q.size();
        do_pop  = r && (n > 0);
        do_push = v && ((n < DEPTH) || do_pop);
        do_drop = v && (n == DEPTH) && !do_pop;
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(d);
        if (do_drop)  m_ovr = 1'b1;
        else if (c)   m_ovr = 1'b0;
        if (do_push || do_pop)                          m_ticks = 0;
        else if ((n > 0) && p && (m_ticks < TO_TICKS))  m_ticks++;
        @(posedge clk);
        #2;
        valid_rx    = 1'b0;
        rd_en       = 1'b0;
        pls_rx      = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_ovr   = 1'b0;
        m_ticks = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic push_b(input logic [DATA_W-1:0] d);
        tick(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_b();
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst         = 1'b1;
        valid_rx    = 1'b0;
        rsr         = '0;
        pls_rx      = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        thresh      = '0;
        m_ovr       = 1'b0;
        m_ticks     = 0;
        do_reset();
        run = 1'b1;

        // 1: basic push / pop ordering and latency
        chk("t1_reset_level", 32'(level), 32'd0);
        chk("t1_reset_empty", 32'(empty), 32'd1);
        chk("t1_reset_rd_data", 32'(rd_data), 32'd0);
        push_b(8'h0F);
        chk("t1_level1", 32'(level), 32'd1);
        chk("t1_head", 32'(rd_data), 32'h0F);
        push_b(8'hA5);
        chk("t1_level2", 32'(level), 32'd2);
        pop_b();
        chk("t1_next", 32'(rd_data), 32'hA5);
        pop_b();
        chk("t1_empty", 32'(empty), 32'd1);
        pop_b();  // pop while empty is ignored
        chk("t1_empty_pop_level", 32'(level), 32'd0);
        chk("t1_empty_pop_ovr", 32'(overrun), 32'd0);

        // 2: fill past capacity, overrun, drain, clear
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            push_b(8'(i));
            if (i == 15) chk("t2_full_at16", 32'(full), 32'd1);
        end
        chk("t2_overrun", 32'(overrun), 32'd1);
        chk("t2_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_read", 32'(rd_data), 32'(i));
            pop_b();
        end
        chk("t2_drained", 32'(empty), 32'd1);
        chk("t2_sticky", 32'(overrun), 32'd1);
        // drop and clear in the same cycle: drop wins
        for (int i = 0; i < 16; i++) push_b(8'(8'h80 + i));
        tick(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("t2_drop_beats_clr", 32'(overrun), 32'd1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t2_cleared", 32'(overrun), 32'd0);

        // 3: push + pop while full
        do_reset();
        for (int i = 0; i < 16; i++) push_b(8'(i));
        tick(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_overrun", 32'(overrun), 32'd0);
        chk("t3_head", 32'(rd_data), 32'd1);
        for (int i = 0; i < 15; i++) pop_b();
        chk("t3_last_level", 32'(level), 32'd1);
        chk("t3_last", 32'(rd_data), 32'h55);
        pop_b();
        chk("t3_empty", 32'(empty), 32'd1);

        // 4: character timeout
        do_reset();
        push_b(8'h3C);
        for (int i = 1; i <= TO_TICKS; i++) begin
            tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (i == TO_TICKS - 1) chk("t4_before", 32'(timeout), 32'd0);
        end
        chk("t4_expired", 32'(timeout), 32'd1);
        pop_b();
        chk("t4_cleared", 32'(timeout), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);
        // sparse ticks, a push mid-window restarts it, expiry then push leaves it
        push_b(8'h11);
        push_b(8'h22);
        for (int i = 0; i < 40; i++) tick(1'b0, '0, 1'b0, 1'(i % 2), 1'b0);
        push_b(8'h33);
        for (int i = 0; i < 63; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t4_restart", 32'(timeout), 32'd0);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t4_expired2", 32'(timeout), 32'd1);
        push_b(8'h44);
        chk("t4_push_leaves", 32'(timeout), 32'd0);
        for (int i = 0; i < 70; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        pop_b();
        chk("t4_pop_nonempty", 32'(timeout), 32'd0);
        chk("t4_level3", 32'(level), 32'd3);

        // 5: level threshold interrupt
        do_reset();
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) push_b(8'(8'hC0 + i));
        chk("t5_below", 32'(irq_thresh), 32'd0);
        push_b(8'hC3);
        chk("t5_at", 32'(irq_thresh), 32'd1);
        pop_b();
        chk("t5_fall", 32'(irq_thresh), 32'd0);
        thresh = 5'd0;
        for (int i = 0; i < 13; i++) push_b(8'(i));
        #1;
        chk("t5_disabled_full", 32'(irq_thresh), 32'd0);
        thresh = 5'd17;
        #1;
        chk("t5_above_depth", 32'(irq_thresh), 32'd0);
        thresh = 5'd16;
        #1;
        chk("t5_at_depth", 32'(irq_thresh), 32'd1);
        thresh = 5'd0;

        // 6: reset mid-operation discards contents, then normal traffic resumes
        do_reset();
        push_b(8'h01);
        push_b(8'h02);
        push_b(8'h03);
        do_reset();
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_level", 32'(level), 32'd0);
        push_b(8'h0F);
        push_b(8'hF0);
        chk("t6_first", 32'(rd_data), 32'h0F);
        pop_b();
        chk("t6_second", 32'(rd_data), 32'hF0);
        pop_b();
        chk("t6_drained", 32'(empty), 32'd1);

        @(negedge clk);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
